// File: rtl/cpu_pkg.sv
// Shared fetch-side types: the bank entry layout and the fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // One instruction-bank entry: the fetched word together with its address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // RUN: returned words go to the bank. DRAIN: stale returns are being dropped.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with count/full/empty and a synchronous clear.
// DEPTH need not be a power of two; pointers wrap explicitly.
// The head entry is presented combinationally on dout.
module if_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; clear empties the queue without touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; zeroed on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch front end: issues bus requests under a credit limit,
// tracks in-flight addresses, buffers returned words in a bank toward
// pre-decode, and drops stale returns after a redirect.
// Optional macro IF_FETCH_BYPASS_EN: forwards a returning word straight to
// pre-decode in the same cycle when the bank is empty.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | no stale returns owed; returned words are delivered
// ST_DRAIN | discard_cnt stale returns still owed by the bus after flush
module if_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned BANK_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic        pd_ready,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fetch_stall,
  output logic        inst_bank_valid,
  output logic [31:0] pd_inst,
  output logic [31:0] pd_pc
);

  localparam int unsigned OW = cnt_w(MAX_OUTSTANDING);
  localparam int unsigned BW = cnt_w(BANK_DEPTH);
  localparam int unsigned SW = cnt_w(MAX_OUTSTANDING + BANK_DEPTH);

  fetch_state_t  state, state_next;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt, discard_next;

  logic          credit;
  logic          accept;
  logic          ret;
  logic          drop;
  logic          keep;
  logic          byp_hit;

  logic [31:0]   pend_pc;
  logic          pend_full;
  logic          pend_empty;

  fetch_entry_t  bank_din;
  fetch_entry_t  bank_head;
  logic          bank_push;
  logic          bank_pop;
  logic          bank_full;
  logic          bank_empty;
  logic [BW-1:0] bank_count;

  // The pending-PC queue occupancy is the outstanding-request count.
  assign credit = (SW'(outstanding) < SW'(MAX_OUTSTANDING))
               && ((SW'(outstanding) + SW'(bank_count)) < SW'(BANK_DEPTH))
               && !pend_full && !bank_full;

  assign inst_req    = credit && !flush && !reset;
  assign inst_addr   = npc;
  assign accept      = inst_req && inst_addr_ok;
  assign fetch_stall = !accept;

  // A return with nothing pending is not a legal bus response and is ignored.
  assign ret  = inst_data_ok && !pend_empty;
  assign drop = ret && (discard_cnt != '0);
  assign keep = ret && (discard_cnt == '0);

`ifdef IF_FETCH_BYPASS_EN
  assign byp_hit   = keep && bank_empty && !flush;
  assign bank_push = keep && !flush && !(byp_hit && pd_ready);
`else
  assign byp_hit   = 1'b0;
  assign bank_push = keep && !flush;
`endif

  assign bank_pop      = pd_ready && !bank_empty;
  assign bank_din.pc   = pend_pc;
  assign bank_din.inst = inst_rdata;

  assign inst_bank_valid = !bank_empty || byp_hit;
  assign pd_inst         = byp_hit ? inst_rdata : bank_head.inst;
  assign pd_pc           = byp_hit ? pend_pc    : bank_head.pc;

  if_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .push  (accept),
    .din   (npc),
    .pop   (ret),
    .dout  (pend_pc),
    .full  (pend_full),
    .empty (pend_empty),
    .count (outstanding)
  );

  if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BANK_DEPTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (bank_push),
    .din   (bank_din),
    .pop   (bank_pop),
    .dout  (bank_head),
    .full  (bank_full),
    .empty (bank_empty),
    .count (bank_count)
  );

  // Discard reload on flush counts every request the bus still owes after this cycle.
  always_comb begin
    discard_next = discard_cnt;
    state_next   = state;
    if (flush) begin
      discard_next = outstanding + OW'(accept) - OW'(ret);
    end else if (drop) begin
      discard_next = discard_cnt - OW'(1);
    end
    case (state)
      ST_RUN:   if (flush && (discard_next != '0)) state_next = ST_DRAIN;
      ST_DRAIN: if (!flush && (discard_next == '0)) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Stale-return counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) discard_cnt <= '0;
    else       discard_cnt <= discard_next;
  end

endmodule
